// File: rtl/reg_context_switcher.sv
// Save/restore engine that streams x1..x31 between reg_file and a per-context store.
// Optional CTX_CHECKSUM_EN: per-context XOR checksum verified on restore.
module reg_context_switcher #(
  parameter int NUM_CTX = 4,
  parameter int CTX_W   = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START_SAVE,
  input  logic             START_RESTORE,
  input  logic [CTX_W-1:0] SAVE_CTX,
  input  logic [CTX_W-1:0] LOAD_CTX,
  output logic             BUSY,
  output logic             STALL,
  output logic             DONE,
  output logic             ERR,
  output logic [4:0]       RF_OUTADDR,
  input  logic [31:0]      RF_OUTDATA,
  output logic [4:0]       RF_INADDR,
  output logic [31:0]      RF_INDATA,
  output logic             RF_WRITE
);

  typedef enum logic [1:0] {S_IDLE, S_SAVE, S_RESTORE, S_FIN} state_t;

  localparam logic [CTX_W:0] LP_NUM_CTX = (CTX_W+1)'(NUM_CTX);

  state_t             r_state, w_next;
  logic [4:0]         r_idx;
  logic [CTX_W-1:0]   r_save_ctx, r_load_ctx;
  logic               r_swap, r_err;
  logic [31:0]        r_store [NUM_CTX][32];

  logic               w_save_bad, w_load_bad, w_start, w_reject, w_last;
  logic [31:0]        w_rd_word;

  assign w_save_bad = {1'b0, SAVE_CTX} >= LP_NUM_CTX;
  assign w_load_bad = {1'b0, LOAD_CTX} >= LP_NUM_CTX;
  assign w_start    = START_SAVE | START_RESTORE;
  assign w_reject   = (START_SAVE & w_save_bad) | (START_RESTORE & w_load_bad);
  assign w_last     = (r_idx == 5'd31);
  assign w_rd_word  = r_store[r_load_ctx][r_idx];

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    ERR        = 1'b0;
    RF_OUTADDR = '0;
    RF_INADDR  = '0;
    RF_INDATA  = '0;
    RF_WRITE   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_reject)        w_next = S_FIN;
          else if (START_SAVE) w_next = S_SAVE;
          else                 w_next = S_RESTORE;
        end
      end
      S_SAVE: begin
        BUSY       = 1'b1;
        RF_OUTADDR = r_idx;
        if (w_last) w_next = r_swap ? S_RESTORE : S_FIN;
      end
      S_RESTORE: begin
        BUSY      = 1'b1;
        RF_WRITE  = 1'b1;
        RF_INADDR = r_idx;
        RF_INDATA = w_rd_word;
        if (w_last) w_next = S_FIN;
      end
      S_FIN: begin
        DONE   = 1'b1;
        ERR    = r_err;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign STALL = BUSY;

  // Context store is deliberately not reset so contexts survive a RESET.
  always_ff @(posedge CLK) begin
    if (!RESET && r_state == S_SAVE) r_store[r_save_ctx][r_idx] <= RF_OUTDATA;
  end

`ifdef CTX_CHECKSUM_EN
  logic [31:0] r_acc;
  logic [31:0] r_chk [NUM_CTX];
  logic [31:0] w_acc_next;

  assign w_acc_next = r_acc ^ ((r_state == S_SAVE) ? RF_OUTDATA : w_rd_word);
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_idx      <= 5'd1;
      r_save_ctx <= '0;
      r_load_ctx <= '0;
      r_swap     <= 1'b0;
      r_err      <= 1'b0;
`ifdef CTX_CHECKSUM_EN
      r_acc      <= '0;
      for (int unsigned i = 0; i < NUM_CTX; i++) r_chk[i] <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_save_ctx <= SAVE_CTX;
            r_load_ctx <= LOAD_CTX;
            r_swap     <= START_SAVE & START_RESTORE;
            r_err      <= w_reject;
            r_idx      <= 5'd1;
`ifdef CTX_CHECKSUM_EN
            r_acc      <= '0;
`endif
          end
        end
        S_SAVE: begin
          r_idx <= w_last ? 5'd1 : r_idx + 5'd1;
`ifdef CTX_CHECKSUM_EN
          r_acc <= w_last ? '0 : w_acc_next;
          if (w_last) r_chk[r_save_ctx] <= w_acc_next;
`endif
        end
        S_RESTORE: begin
          r_idx <= w_last ? 5'd1 : r_idx + 5'd1;
`ifdef CTX_CHECKSUM_EN
          r_acc <= w_last ? '0 : w_acc_next;
          if (w_last && (w_acc_next != r_chk[r_load_ctx])) r_err <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
